imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator that replaces the single-cycle combinational immediate unit. It accepts instr[31:7] plus an immediate-format select under a valid/ready handshake. It produces the XLEN-wide extended immediate after PIPE_DEPTH register stages, with backpressure, flush and an illegal-format flag. It sits between decode and the execute operand muxes of the pipelined core.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
PIPE_DEPTH, 1, number of register stages; legal range 1..4.
TAG_W, 5, width of sideband tag (e.g. rd) carried alongside each item.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous kill of all in-flight items
in_valid  in  1  input item present
in_ready  out  1  unit can accept an item this cycle
imm_in  in  25  instruction bits [31:7]; imm_in[k] = instr[k+7]
imm_src  in  3  format select
tag_in  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  output item present
out_ready  in  1  consumer accepts output this cycle
imm_out  out  XLEN  extended immediate
imm_err  out  1  item had an illegal imm_src
tag_out  out  TAG_W  sideband of the output item

Behaviour:
- Format decode is combinational, before stage 0 register. s = imm_in[24], sign-extended to XLEN:
  - 000 I: sext(imm_in[24:13]).
  - 001 S: sext({imm_in[24:18], imm_in[4:0]}).
  - 101 B: sext({imm_in[24], imm_in[0], imm_in[23:18], imm_in[4:1], 1'b0}).
  - 010 U: sext({imm_in[24:5], 12'b0}); for XLEN=64 bits 63:32 equal s.
  - 110 J: sext({imm_in[24], imm_in[12:5], imm_in[13], imm_in[23:14], 1'b0}).
  - 011 CSR zimm: zero-extend imm_in[12:8].
  - 100 shamt: zero-extend imm_in[17:13] (XLEN=32) or imm_in[18:13] (XLEN=64).
  - 111: imm = 0 and imm_err = 1. imm_err = 0 for every other code.
- Pipeline: stages 0..PIPE_DEPTH-1, each holding valid, imm, err, tag. Output ports are driven directly from the last stage.
- Advance rule:
  - Last stage advances when !valid or out_ready.
  - Stage k advances when stage k+1 advances or stage k is empty.
  - in_ready = stage-0 advance condition; it is combinational from state and out_ready, never from in_valid.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - A stalled stage holds all fields bit-stable.
- Latency: an item accepted at edge N is presented on out_valid after edge N+PIPE_DEPTH-1, i.e. visible PIPE_DEPTH cycles after acceptance when there are no stalls.
- Throughput: one item per cycle while out_ready is held high.
- Full pipeline with out_ready=0: in_ready=0. Simultaneous out_ready=1 and in_valid=1 on a full pipeline accepts the new item the same cycle, with no bubble.
- flush=1: at the next edge all stage valids clear. Any item presented on the input that cycle is discarded. flush has priority over all transfers.
- Reset (async assert, any time including mid-stall):
  - all valids 0, imm 0, err 0, tag 0;
  - out_valid=0, imm_out=0, imm_err=0, tag_out=0;
  - in_ready=1 while rst_n is low and after release.
- Data fields of empty stages are don't-care to consumers but must not be X after reset.
- Illegal parameter values are a synthesis-time error.

Test Plan:
- XLEN=32, PIPE_DEPTH=1, out_ready=1. Send these items back-to-back:
  - imm_in=0xFFF00093>>7, src=000 -> imm_out=0xFFFFFFFF, err=0, 1 cycle later.
  - 0xFE000EE3>>7, src=101 -> 0xFFFFFFFC.
  - 0x0080006F>>7, src=110 -> 0x00000008.
  - 0x123450B7>>7, src=010 -> 0x12345000.
  - 0x000FD073>>7, src=011 -> 0x0000001F.
- XLEN=64: 0x800000B7>>7, src=010 -> 0xFFFFFFFF80000000. 0x03F0D093>>7, src=100 -> 0x000000000000003F.
- src=111 with any imm_in -> imm_out=0, imm_err=1. Next item with src=000 -> imm_err=0.
- PIPE_DEPTH=3 backpressure:
  - out_ready=0, stream 5 items; in_ready drops after 3 accepted.
  - Raise out_ready; all 5 emerge in order, tags 0..4, none lost or duplicated, outputs stable while stalled.
- PIPE_DEPTH=3 with 3 items in flight: pulse flush with in_valid=1 -> out_valid=0 next cycle, the flushed-cycle input never appears, in_ready=1.
- Drop rst_n asynchronously mid-stall with the pipeline full -> out_valid=0 and imm_out=0 immediately, without waiting for a clock edge. After release, in_ready=1 and the first new item appears PIPE_DEPTH cycles after acceptance.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with valid/ready handshake, flush and illegal-format flag
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kills every in-flight item at the next edge
//   in_valid/in_ready   input handshake; imm_in = instr[31:7], imm_src = format, tag_in = sideband
//   out_valid/out_ready output handshake; imm_out = extended immediate, imm_err = illegal format, tag_out
module imm_gen_pipe #(
   parameter int XLEN       = 32,
   parameter int PIPE_DEPTH = 1,
   parameter int TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      imm_in,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic             imm_err,
   output logic [TAG_W-1:0] tag_out
);
   localparam int L = PIPE_DEPTH - 1;

   if (!(XLEN == 32 || XLEN == 64) || PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_param
      $error("imm_gen_pipe: XLEN must be 32/64 and PIPE_DEPTH 1..4");
   end

   logic                         s;
   logic [31:0]                  imm32;
   logic [XLEN-1:0]              dec_imm;
   logic                         dec_err;
   logic [L:0]                   v, adv, nv, nerr;
   logic [L:0][XLEN-1:0]         imm_q, nimm;
   logic [L:0]                   err_q;
   logic [L:0][TAG_W-1:0]        tag_q, ntag;

   // Every format is built as a 32-bit value whose bit 31 is the correct
   // extension bit (zero for zimm/shamt/illegal), so one sign-extension to
   // XLEN serves all of them.
   always_comb begin
      s       = imm_in[24];
      imm32   = '0;
      dec_err = 1'b0;
      case (imm_src)
         3'b000: imm32 = {{20{s}}, imm_in[24:13]};
         3'b001: imm32 = {{20{s}}, imm_in[24:18], imm_in[4:0]};
         3'b101: imm32 = {{19{s}}, imm_in[24], imm_in[0], imm_in[23:18], imm_in[4:1], 1'b0};
         3'b010: imm32 = {imm_in[24:5], 12'b0};
         3'b110: imm32 = {{11{s}}, imm_in[24], imm_in[12:5], imm_in[13], imm_in[23:14], 1'b0};
         3'b011: imm32 = {27'b0, imm_in[12:8]};
         3'b100: imm32 = XLEN == 64 ? {26'b0, imm_in[18:13]} : {27'b0, imm_in[17:13]};
         default: dec_err = 1'b1;
      endcase
   end

   assign dec_imm = XLEN'($signed(imm32));

   // Stage k may advance unless it and every stage after it is full while
   // the consumer stalls; written in closed form to avoid a ripple chain.
   always_comb begin
      nv      = '0;
      nimm    = '0;
      nerr    = '0;
      ntag    = '0;
      nv[0]   = in_valid;
      nimm[0] = dec_imm;
      nerr[0] = dec_err;
      ntag[0] = tag_in;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         nv[k]   = v[k-1];
         nimm[k] = imm_q[k-1];
         nerr[k] = err_q[k-1];
         ntag[k] = tag_q[k-1];
      end
      for (int k = 0; k < PIPE_DEPTH; k++)
         adv[k] = out_ready | ~&(v | PIPE_DEPTH'((1 << k) - 1));
   end

   // Data fields load only when a valid item moves in, so stalled and empty
   // stages keep their contents bit-stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v     <= '0;
         imm_q <= '0;
         err_q <= '0;
         tag_q <= '0;
      end else begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            v[k] <= flush ? 1'b0 : adv[k] ? nv[k] : v[k];
            if (adv[k] && nv[k]) begin
               imm_q[k] <= nimm[k];
               err_q[k] <= nerr[k];
               tag_q[k] <= ntag[k];
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v[L];
   assign imm_out   = imm_q[L];
   assign imm_err   = err_q[L];
   assign tag_out   = tag_q[L];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vector bench for imm_gen_pipe at XLEN=32/64 depth 1 and XLEN=32 depth 3
module tb_imm_gen_pipe;
   typedef struct {
      logic [31:0] ins;
      logic [2:0]  src;
      logic [63:0] exp;
      logic        err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_fl = 0, a_iv = 0, a_ir, a_ov, a_or = 0, a_er;
   logic [24:0] a_imi = '0;
   logic [2:0]  a_src = '0;
   logic [4:0]  a_tgi = '0, a_tgo;
   logic [31:0] a_imo;

   logic        b_fl = 0, b_iv = 0, b_ir, b_ov, b_or = 0, b_er;
   logic [24:0] b_imi = '0;
   logic [2:0]  b_src = '0;
   logic [4:0]  b_tgi = '0, b_tgo;
   logic [63:0] b_imo;

   logic        c_fl = 0, c_iv = 0, c_ir, c_ov, c_or = 0, c_er;
   logic [24:0] c_imi = '0;
   logic [2:0]  c_src = '0;
   logic [4:0]  c_tgi = '0, c_tgo;
   logic [31:0] c_imo;

   imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1), .TAG_W(5)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
      .imm_in(a_imi), .imm_src(a_src), .tag_in(a_tgi), .out_valid(a_ov),
      .out_ready(a_or), .imm_out(a_imo), .imm_err(a_er), .tag_out(a_tgo));

   imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(1), .TAG_W(5)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
      .imm_in(b_imi), .imm_src(b_src), .tag_in(b_tgi), .out_valid(b_ov),
      .out_ready(b_or), .imm_out(b_imo), .imm_err(b_er), .tag_out(b_tgo));

   imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(3), .TAG_W(5)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
      .imm_in(c_imi), .imm_src(c_src), .tag_in(c_tgi), .out_valid(c_ov),
      .out_ready(c_or), .imm_out(c_imo), .imm_err(c_er), .tag_out(c_tgo));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // addi-style item whose I-immediate equals its tag
   task automatic c_put(input logic v, input logic [4:0] t);
      logic [31:0] ins;
      ins   = {7'b0, t, 20'h00013};
      c_iv  = v;
      c_imi = ins[31:7];
      c_src = 3'b000;
      c_tgi = t;
   endtask

   vec_t ta[9];
   vec_t tb[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      logic [31:0] saved_imm;
      logic [4:0]  saved_tag;
      int          k, n_out, lat;
      logic        seen;

      ta[0] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF, 1'b0};
      ta[1] = '{32'hFE000EE3, 3'b101, 64'hFFFFFFFC, 1'b0};
      ta[2] = '{32'h0080006F, 3'b110, 64'h00000008, 1'b0};
      ta[3] = '{32'h123450B7, 3'b010, 64'h12345000, 1'b0};
      ta[4] = '{32'h000FD073, 3'b011, 64'h0000001F, 1'b0};
      ta[5] = '{32'h00112623, 3'b001, 64'h0000000C, 1'b0};
      ta[6] = '{32'h03F0D093, 3'b100, 64'h0000001F, 1'b0};
      ta[7] = '{32'hDEADBEEF, 3'b111, 64'h00000000, 1'b1};
      ta[8] = '{32'h00500093, 3'b000, 64'h00000005, 1'b0};
      tb[0] = '{32'h800000B7, 3'b010, 64'hFFFFFFFF80000000, 1'b0};
      tb[1] = '{32'h03F0D093, 3'b100, 64'h000000000000003F, 1'b0};
      tb[2] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      tb[3] = '{32'hFE000EE3, 3'b101, 64'hFFFFFFFFFFFFFFFC, 1'b0};

      #3;
      chk("rst a out_valid", 64'(a_ov), 64'd0);
      chk("rst a imm_out", 64'(a_imo), 64'd0);
      chk("rst a in_ready", 64'(a_ir), 64'd1);
      chk("rst b imm_out", b_imo, 64'd0);
      chk("rst c out_valid", 64'(c_ov), 64'd0);
      chk("rst c tag_out", 64'(c_tgo), 64'd0);
      chk("rst c imm_err", 64'(c_er), 64'd0);
      chk("rst c in_ready", 64'(c_ir), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      a_or = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("a[%0d] out_valid", i-1), 64'(a_ov), 64'd1);
            chk($sformatf("a[%0d] imm_out", i-1), 64'(a_imo), 64'(ta[i-1].exp[31:0]));
            chk($sformatf("a[%0d] imm_err", i-1), 64'(a_er), 64'(ta[i-1].err));
            chk($sformatf("a[%0d] tag_out", i-1), 64'(a_tgo), 64'(i-1));
            chk($sformatf("a[%0d] in_ready", i-1), 64'(a_ir), 64'd1);
         end
         if (i < 9) begin
            ins   = ta[i].ins;
            a_iv  = 1'b1;
            a_imi = ins[31:7];
            a_src = ta[i].src;
            a_tgi = 5'(i);
         end else a_iv = 1'b0;
      end
      @(negedge clk);
      chk("a drained out_valid", 64'(a_ov), 64'd0);

      b_or = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("b[%0d] out_valid", i-1), 64'(b_ov), 64'd1);
            chk($sformatf("b[%0d] imm_out", i-1), b_imo, tb[i-1].exp);
            chk($sformatf("b[%0d] imm_err", i-1), 64'(b_er), 64'(tb[i-1].err));
         end
         if (i < 4) begin
            ins   = tb[i].ins;
            b_iv  = 1'b1;
            b_imi = ins[31:7];
            b_src = tb[i].src;
            b_tgi = 5'(i);
         end else b_iv = 1'b0;
      end

      k = 0;
      n_out = 0;
      saved_imm = '0;
      saved_tag = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         c_or = cyc >= 6;
         if (k < 5) c_put(1'b1, 5'(k));
         else c_iv = 1'b0;
         #1;
         if (cyc == 3) begin
            saved_imm = c_imo;
            saved_tag = c_tgo;
         end
         if (cyc == 5) begin
            chk("bp accepted before stall", 64'(k), 64'd3);
            chk("bp in_ready when full", 64'(c_ir), 64'd0);
            chk("bp out_valid stalled", 64'(c_ov), 64'd1);
            chk("bp imm stable", 64'(c_imo), 64'(saved_imm));
            chk("bp tag stable", 64'(c_tgo), 64'(saved_tag));
            chk("bp head tag", 64'(c_tgo), 64'd0);
         end
         if (c_ov && c_or) begin
            chk($sformatf("bp out%0d tag", n_out), 64'(c_tgo), 64'(n_out));
            chk($sformatf("bp out%0d imm", n_out), 64'(c_imo), 64'(n_out));
            n_out++;
         end
         if (c_iv && c_ir) k++;
      end
      chk("bp items out", 64'(n_out), 64'd5);
      chk("bp items in", 64'(k), 64'd5);
      chk("bp drained out_valid", 64'(c_ov), 64'd0);

      c_or = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         c_put(1'b1, 5'(10 + i));
         #1;
         chk($sformatf("fl accept%0d in_ready", i), 64'(c_ir), 64'd1);
      end
      @(negedge clk);
      c_put(1'b1, 5'd13);
      c_fl = 1'b1;
      @(negedge clk);
      c_fl = 1'b0;
      c_iv = 1'b0;
      #1;
      chk("fl out_valid", 64'(c_ov), 64'd0);
      chk("fl in_ready", 64'(c_ir), 64'd1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (c_ov) seen = 1'b1;
      end
      chk("fl nothing emerges", 64'(seen), 64'd0);

      c_or = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         c_put(1'b1, 5'(20 + i));
      end
      @(negedge clk);
      c_iv = 1'b0;
      #1;
      chk("ar full out_valid", 64'(c_ov), 64'd1);
      chk("ar full tag", 64'(c_tgo), 64'd20);
      chk("ar full in_ready", 64'(c_ir), 64'd0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar out_valid", 64'(c_ov), 64'd0);
      chk("ar imm_out", 64'(c_imo), 64'd0);
      chk("ar tag_out", 64'(c_tgo), 64'd0);
      chk("ar in_ready", 64'(c_ir), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ar release in_ready", 64'(c_ir), 64'd1);
      c_or = 1'b1;
      c_put(1'b1, 5'd7);
      lat = 0;
      do begin
         @(negedge clk);
         c_iv = 1'b0;
         lat++;
      end while (!c_ov && lat < 10);
      chk("ar latency", 64'(lat), 64'd3);
      chk("ar first tag", 64'(c_tgo), 64'd7);
      chk("ar first imm", 64'(c_imo), 64'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
